// File: rtl/sbox_masked_driver.sv
// Initiator for a clock-gated masked S-box: holds three input shares on SI, restarts the
// gating controller, waits for Synch (with watchdog), then offers the SO shares downstream.
module sbox_masked_driver #(
    parameter int LATENCY = 11,
    parameter int TIMEOUT = 15,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s0,
    input  logic [WIDTH-1:0] in_s1,
    input  logic [WIDTH-1:0] in_s2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s0,
    output logic [WIDTH-1:0] out_s1,
    output logic [WIDTH-1:0] out_s2,
    output logic [WIDTH-1:0] sbox_si_s0,
    output logic [WIDTH-1:0] sbox_si_s1,
    output logic [WIDTH-1:0] sbox_si_s2,
    input  logic [WIDTH-1:0] sbox_so_s0,
    input  logic [WIDTH-1:0] sbox_so_s1,
    input  logic [WIDTH-1:0] sbox_so_s2,
    input  logic             sbox_synch,
    output logic             sbox_rst,
    output logic             busy,
    output logic             err
);

    // A misconfigured TIMEOUT never fires before the expected Synch.
    localparam int WD_MAX = (TIMEOUT > LATENCY) ? TIMEOUT - 1 : LATENCY;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  si0_q, si1_q, si2_q, si0_d, si1_d, si2_d;
    logic [WIDTH-1:0]  out0_q, out1_q, out2_q, out0_d, out1_d, out2_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              sbox_rst_q, sbox_rst_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        si0_d   = si0_q;
        si1_d   = si1_q;
        si2_d   = si2_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    si0_d   = in_s0;
                    si1_d   = in_s1;
                    si2_d   = in_s2;
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Synch takes priority over a timeout landing on the same cycle.
                if (sbox_synch) begin
                    out0_d  = sbox_so_s0;
                    out1_d  = sbox_so_s1;
                    out2_d  = sbox_so_s2;
                    si0_d   = '0;
                    si1_d   = '0;
                    si2_d   = '0;
                    state_d = S_HOLD;
                end else if (wd_q == WD_W'(WD_MAX)) begin
                    err_d   = 1'b1;
                    si0_d   = '0;
                    si1_d   = '0;
                    si2_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out0_d  = '0;
                    out1_d  = '0;
                    out2_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        sbox_rst_d  = (state_d != S_WAIT);
        out_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            si0_q       <= '0;
            si1_q       <= '0;
            si2_q       <= '0;
            out0_q      <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            sbox_rst_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            si0_q       <= si0_d;
            si1_q       <= si1_d;
            si2_q       <= si2_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            sbox_rst_q  <= sbox_rst_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign sbox_rst   = sbox_rst_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign sbox_si_s0 = si0_q;
    assign sbox_si_s1 = si1_q;
    assign sbox_si_s2 = si2_q;
    assign out_s0     = out0_q;
    assign out_s1     = out1_q;
    assign out_s2     = out2_q;

endmodule

// File: tb/tb_sbox_masked_driver.sv
// Directed bench for sbox_masked_driver with a behavioural gated S-box (Synch on the
// LATENCY-th cycle after sbox_rst release).
module tb_sbox_masked_driver;

    localparam int LATENCY = 11;
    localparam int TIMEOUT = 15;
    localparam int WIDTH   = 4;

    logic             clk, rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_s0, in_s1, in_s2;
    logic [WIDTH-1:0] out_s0, out_s1, out_s2;
    logic [WIDTH-1:0] si0, si1, si2, so0, so1, so2;
    logic             sbox_synch, sbox_rst, busy, err;

    logic             synch_en, stray, use_map, model_synch;
    logic [WIDTH-1:0] fix0, fix1, fix2;
    int               mcnt;
    int               n_run, n_fail;
    int               lat, low;
    logic [11:0]      held;

    sbox_masked_driver #(.LATENCY(LATENCY), .TIMEOUT(TIMEOUT), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2),
        .sbox_si_s0(si0), .sbox_si_s1(si1), .sbox_si_s2(si2),
        .sbox_so_s0(so0), .sbox_so_s1(so1), .sbox_so_s2(so2),
        .sbox_synch(sbox_synch), .sbox_rst(sbox_rst),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // S-box model: counts cycles with sbox_rst low, pulses Synch on the LATENCY-th one.
    always @(negedge clk) begin
        if (sbox_rst) begin
            mcnt        = 0;
            model_synch = 1'b0;
        end else begin
            mcnt        = mcnt + 1;
            model_synch = synch_en && (mcnt == LATENCY);
        end
    end

    assign sbox_synch = model_synch | stray;
    assign so0 = use_map ? ~si0 : fix0;
    assign so1 = use_map ? si1 + 4'd1 : fix1;
    assign so2 = use_map ? si2 - 4'd1 : fix2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until out_valid (bounded); reports edges taken and cycles seen with sbox_rst low.
    task automatic wait_out(output int l, output int lo);
        l  = 0;
        lo = 0;
        while (!out_valid && l < 40) begin
            tick();
            l++;
            if (!sbox_rst) lo++;
        end
    endtask

    task automatic start_txn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_s0 = a; in_s1 = b; in_s2 = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_s0 = '0; in_s1 = '0; in_s2 = '0;
        synch_en = 1'b1; stray = 1'b0; use_map = 1'b0;
        fix0 = '0; fix1 = '0; fix2 = '0;
        mcnt = 0; model_synch = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sbox_rst", sbox_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_si", {si0, si1, si2}, 12'h000);
        chk("rst_out", {out_s0, out_s1, out_s2}, 12'h000);
        rst = 1'b0;
        tick();

        // 1: basic transaction with exact cycle timing
        fix0 = 4'h1; fix1 = 4'h2; fix2 = 4'h4;
        start_txn(4'hA, 4'h3, 4'h5);
        chk("t1_start_rst", sbox_rst, 1);
        chk("t1_start_ready", in_ready, 0);
        chk("t1_start_busy", busy, 1);
        chk("t1_start_si", {si0, si1, si2}, 12'hA35);
        tick();
        chk("t1_wait_rst", sbox_rst, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_wait_si", {si0, si1, si2}, 12'hA35);
            chk("t1_wait_rst_low", sbox_rst, 0);
            chk("t1_wait_no_valid", out_valid, 0);
        end
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_out", {out_s0, out_s1, out_s2}, 12'h124);
        chk("t1_si_zero", {si0, si1, si2}, 12'h000);
        chk("t1_hold_rst", sbox_rst, 1);

        // 2: output stalled for 20 cycles; a second request must be ignored
        in_s0 = 4'h7; in_s1 = 4'h7; in_s2 = 4'h7; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2_valid_held", out_valid, 1);
            chk("t2_out_held", {out_s0, out_s1, out_s2}, 12'h124);
            chk("t2_not_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_release_valid", out_valid, 0);
        chk("t2_release_out", {out_s0, out_s1, out_s2}, 12'h000);
        chk("t2_idle_ready", in_ready, 1);
        chk("t2_idle_busy", busy, 0);
        chk("t2_second_ignored", {si0, si1, si2}, 12'h000);

        // 3: Synch never arrives
        synch_en = 1'b0;
        start_txn(4'h6, 4'h6, 4'h6);
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("t3_no_err_yet", err, 0);
            chk("t3_busy", busy, 1);
            chk("t3_no_valid", out_valid, 0);
        end
        tick();
        chk("t3_err", err, 1);
        chk("t3_idle", busy, 0);
        chk("t3_ready", in_ready, 1);
        chk("t3_si_zero", {si0, si1, si2}, 12'h000);
        chk("t3_no_valid_end", out_valid, 0);
        chk("t3_sbox_rst", sbox_rst, 1);
        synch_en = 1'b1;

        // 4: stray Synch in IDLE and in HOLD
        stray = 1'b1;
        tick(); tick();
        stray = 1'b0;
        chk("t4_idle_ready", in_ready, 1);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", out_valid, 0);
        chk("t4_idle_out", {out_s0, out_s1, out_s2}, 12'h000);
        chk("t4_err_sticky", err, 1);
        fix0 = 4'h7; fix1 = 4'h8; fix2 = 4'h9;
        start_txn(4'hF, 4'h0, 4'h6);
        wait_out(lat, low);
        chk("t4_latency", lat, 12);
        chk("t4_out", {out_s0, out_s1, out_s2}, 12'h789);
        fix0 = 4'h0; fix1 = 4'h0; fix2 = 4'h0;
        stray = 1'b1;
        tick(); tick();
        stray = 1'b0;
        chk("t4_hold_valid", out_valid, 1);
        chk("t4_hold_out", {out_s0, out_s1, out_s2}, 12'h789);
        chk("t4_hold_rst", sbox_rst, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_done", out_valid, 0);

        // 5: back-to-back with in_valid and out_ready held high
        use_map = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin in_s0 = 4'h1; in_s1 = 4'h2; in_s2 = 4'h3; held = 12'hE32; end
                1: begin in_s0 = 4'h4; in_s1 = 4'h5; in_s2 = 4'h6; held = 12'hB65; end
                2: begin in_s0 = 4'h7; in_s1 = 4'h8; in_s2 = 4'h9; held = 12'h898; end
                default: begin in_s0 = 4'hB; in_s1 = 4'hC; in_s2 = 4'hD; held = 12'h4DC; end
            endcase
            tick();
            chk("t5_start_rst", sbox_rst, 1);
            chk("t5_start_busy", busy, 1);
            wait_out(lat, low);
            chk("t5_latency", lat, 12);
            chk("t5_rst_low_cycles", low, LATENCY);
            chk("t5_out", {out_s0, out_s1, out_s2}, {20'h0, held});
            tick();
            if (k == 3) in_valid = 1'b0;
            chk("t5_valid_drop", out_valid, 0);
            chk("t5_back_idle", in_ready, 1);
        end
        out_ready = 1'b0; use_map = 1'b0;

        // 6: reset in the middle of WAIT
        fix0 = 4'hC; fix1 = 4'h0; fix2 = 4'hF;
        start_txn(4'h2, 4'h4, 4'h6);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_in_wait", sbox_rst, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_sbox_rst", sbox_rst, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_si", {si0, si1, si2}, 12'h000);
        chk("t6_rst_out", {out_s0, out_s1, out_s2}, 12'h000);
        chk("t6_rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        start_txn(4'h9, 4'h9, 4'h9);
        wait_out(lat, low);
        chk("t6_latency", lat, 12);
        chk("t6_out", {out_s0, out_s1, out_s2}, 12'hC0F);
        chk("t6_err_clear", err, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_done", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
